fir_accum: RTL and testbench

- Downstream neighbour of the constant-coefficient multiplier stage in the FIR filter datapath.
- Consumes the multiplier's valid-qualified product stream (R_IN/D_IN) and sums TAPS consecutive valid products into one filter output sample.
- Emits each sum with a one-cycle-registered R_OUT using the same EN/R_IN/R_OUT convention as the multiplier stage, so stages chain directly.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_accum.sv | 105 ++++++++++
 tb/tb_fir_accum.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR datapath package: default widths, the clog2 helper and the
// accumulator state encoding used by fir_accum.
package fir_pkg;

  // Default product width and tap count shared with the multiplier stage.
  localparam int FIR_N    = 16;
  localparam int FIR_TAPS = 4;

  // Ceiling log2; returns 0 for value <= 1 so a single-tap filter adds no bits.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // IDLE: no partial frame held. ACCUM: 0 < cnt < TAPS.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/fir_accum.sv
// FIR output accumulator: sums TAPS consecutive valid products into one
// output sample with a registered R_OUT. Optional macro FIR_ACC_SAT_EN
// narrows D_OUT to N bits and clamps completed sums to all ones.
module fir_accum
  import fir_pkg::*;
#(
  parameter  int N    = FIR_N,
  parameter  int TAPS = FIR_TAPS,
  localparam int W    = N + clog2(TAPS),
`ifdef FIR_ACC_SAT_EN
  localparam int DW   = N,
`else
  localparam int DW   = W,
`endif
  localparam int CW   = (clog2(TAPS) > 0) ? clog2(TAPS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          CLR,
  input  logic          R_IN,
  input  logic [N-1:0]  D_IN,
  output logic          R_OUT,
  output logic [DW-1:0] D_OUT,
  output logic          BUSY
);

  acc_state_e    state;
  acc_state_e    state_nx;
  logic [W-1:0]  acc;
  logic [W-1:0]  sum;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dout_nx;
  logic          last;

  // The TAPS-th valid input of a frame completes it (always true for TAPS = 1).
  assign last = (cnt == CW'(TAPS - 1));

  // Running sum including the current product; a new frame starts from D_IN alone.
  always_comb begin
    sum = (cnt == '0) ? W'(D_IN) : acc + W'(D_IN);
  end

  // Output value for a completing frame, clamped when saturation is built in.
  always_comb begin
`ifdef FIR_ACC_SAT_EN
    dout_nx = (sum > W'({N{1'b1}})) ? {N{1'b1}} : sum[N-1:0];
`else
    dout_nx = sum;
`endif
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: CLR aborts to IDLE, a valid input either opens/continues or closes a frame.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    if (EN) begin
      if (CLR)       state_nx = IDLE;
      else if (R_IN) state_nx = last ? IDLE : ACCUM;
    end
  end

  // Output decode: busy while a partial frame is held.
  always_comb begin
    BUSY = (state == ACCUM);
  end

  // Datapath: accumulate, count, and register the completed sum.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc   <= '0;
      cnt   <= '0;
      R_OUT <= 1'b0;
      D_OUT <= '0;
    end else if (EN) begin
      if (CLR) begin
        acc   <= '0;
        cnt   <= '0;
        R_OUT <= 1'b0;
      end else if (R_IN) begin
        if (last) begin
          D_OUT <= dout_nx;
          R_OUT <= 1'b1;
          cnt   <= '0;
        end else begin
          acc   <= sum;
          cnt   <= cnt + CW'(1);
          R_OUT <= 1'b0;
        end
      end else begin
        R_OUT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_accum.sv
// Self-checking bench for fir_accum: directed scenarios followed by random
// traffic compared against a frame-list reference model.
module tb_fir_accum;

  localparam int N    = 16;
  localparam int TAPS = 4;
  localparam int W    = 18;
`ifdef FIR_ACC_SAT_EN
  localparam int DW   = N;
`else
  localparam int DW   = W;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN = 1'b0;
  logic          CLR = 1'b0;
  logic          R_IN = 1'b0;
  logic [N-1:0]  D_IN = '0;
  logic          R_OUT;
  logic [DW-1:0] D_OUT;
  logic          BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: products collected for the frame in progress.
  longint unsigned frame[$];
  bit              m_rout = 1'b0;
  longint unsigned m_dout = 0;

  fir_accum #(.N(N), .TAPS(TAPS)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .CLR  (CLR),
    .R_IN (R_IN),
    .D_IN (D_IN),
    .R_OUT(R_OUT),
    .D_OUT(D_OUT),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned out_value(input longint unsigned s);
`ifdef FIR_ACC_SAT_EN
    return (s > 64'hFFFF) ? 64'hFFFF : s;
`else
    return s;
`endif
  endfunction

  // Apply one cycle of inputs, advance the model, then compare outputs.
  task automatic step(input logic rst, input logic en, input logic clr,
                      input logic rin, input logic [N-1:0] din);
    longint unsigned s;
    RST = rst; EN = en; CLR = clr; R_IN = rin; D_IN = din;
    @(posedge CLK);
    if (rst) begin
      frame.delete();
      m_rout = 1'b0;
      m_dout = 0;
    end else if (en) begin
      if (clr) begin
        frame.delete();
        m_rout = 1'b0;
      end else if (rin) begin
        frame.push_back(longint'(din));
        if (frame.size() == TAPS) begin
          s = 0;
          foreach (frame[i]) s += frame[i];
          m_dout = out_value(s);
          m_rout = 1'b1;
          frame.delete();
        end else begin
          m_rout = 1'b0;
        end
      end else begin
        m_rout = 1'b0;
      end
    end
    #1;
    check("r_out", R_OUT, m_rout);
    check("d_out", D_OUT, m_dout);
    check("busy", BUSY, (frame.size() != 0));
  endtask

  initial begin
    // Reset state.
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_r_out", R_OUT, 0);
    check("rst_d_out", D_OUT, 0);
    check("rst_busy", BUSY, 0);

    // 1,2,3,4 -> 10, BUSY high after inputs 1..3.
    step(0, 1, 0, 1, 16'd1); check("t1_busy1", BUSY, 1);
    step(0, 1, 0, 1, 16'd2); check("t1_busy2", BUSY, 1);
    step(0, 1, 0, 1, 16'd3); check("t1_busy3", BUSY, 1);
    step(0, 1, 0, 1, 16'd4);
    check("t1_rout", R_OUT, 1);
    check("t1_sum", D_OUT, 10);
    check("t1_idle", BUSY, 0);
    step(0, 1, 0, 0, 0); check("t1_rout_drop", R_OUT, 0);

    // Four maximal products.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 16'hFFFF);
`ifdef FIR_ACC_SAT_EN
    check("t2_sat", D_OUT, 64'hFFFF);
`else
    check("t2_full", D_OUT, 64'h3FFFC);
`endif

    // Gaps pause accumulation: 5,-,-,6,7,-,8 -> 26.
    step(0, 1, 0, 1, 16'd5);
    step(0, 1, 0, 0, 16'd99); check("t3_gap1", R_OUT, 0);
    step(0, 1, 0, 0, 16'd99); check("t3_gap2", R_OUT, 0);
    step(0, 1, 0, 1, 16'd6);
    step(0, 1, 0, 1, 16'd7);
    step(0, 1, 0, 0, 16'd99); check("t3_gap3", R_OUT, 0);
    step(0, 1, 0, 1, 16'd8);
    check("t3_rout", R_OUT, 1);
    check("t3_sum", D_OUT, 26);

    // CLR aborts a partial frame and drops its own D_IN.
    step(0, 1, 0, 1, 16'd1);
    step(0, 1, 0, 1, 16'd2);
    step(0, 1, 1, 1, 16'd9);
    check("t4_busy_clr", BUSY, 0);
    check("t4_dout_hold", D_OUT, 26);
    step(0, 1, 0, 1, 16'd10);
    step(0, 1, 0, 1, 16'd20);
    step(0, 1, 0, 1, 16'd30);
    step(0, 1, 0, 1, 16'd40);
    check("t4_sum", D_OUT, 100);

    // EN low holds R_OUT and D_OUT.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 16'd7);
      check("t5_rout_hold", R_OUT, 1);
      check("t5_dout_hold", D_OUT, 100);
    end
    step(0, 1, 0, 0, 0);
    check("t5_rout_clear", R_OUT, 0);

    // Reset discards a partial frame.
    step(0, 1, 0, 1, 16'd3);
    step(0, 1, 0, 1, 16'd3);
    step(1, 1, 0, 1, 16'd3);
    check("t6_rst_dout", D_OUT, 0);
    check("t6_rst_busy", BUSY, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 16'd1);
      check("t6_no_emit", R_OUT, 0);
    end
    step(0, 1, 0, 1, 16'd1);
    check("t6_sum", D_OUT, 4);

    // Randomised traffic, including back-to-back frames and large products.
    for (int i = 0; i < 3000; i++) begin
      logic          r_rst, r_en, r_clr, r_rin;
      logic [N-1:0]  r_din;
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 9) < 8);
      r_clr = ($urandom_range(0, 29) == 0);
      r_rin = ($urandom_range(0, 9) < 7);
      r_din = ($urandom_range(0, 3) == 0) ? 16'hFFFF : N'($urandom);
      step(r_rst, r_en, r_clr, r_rin, r_din);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
